// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit
//   Pipeline-register sequencer for the OTTER 5-stage core. Combines the
//   hazard-unit stall, the EX-stage redirect and the data-memory busy flag
//   into per-stage load enables, flushes and the MEM/WB bubble. A small FSM
//   squashes the wrong-path word returned by the synchronous IMEM after a
//   redirect. Three saturating counters track stall, flush and memory-wait
//   cycles.
//
// Ports
//   clk, rst_n         core clock, synchronous active-low reset
//   stall              hazard-unit stall request
//   ex_redirect        EX-stage taken control transfer
//   mem_busy           data memory cannot finish the MEM access this cycle
//   perf_clr           synchronous clear of all counters
//   pc_en .. ex_mem_en stage load enables
//   if_id_flush        IF/ID loads NOP
//   id_ex_flush        ID/EX loads bubble
//   mem_wb_bubble      MEM/WB loads bubble
//   fsm_state          0 BOOT, 1 RUN, 2 FLUSH
//   *_count            saturating performance counters (CNT_W bits)
module pipeline_control_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    input  logic             perf_clr,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_bubble,
    output logic [1:0]       fsm_state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] mem_wait_count
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] memw_cnt_q,  memw_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        state_d       = state_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        memw_cnt_d    = memw_cnt_q;

        if (!rst_n) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (mem_busy) begin
            // Whole pipe frozen; state holds so a pending BOOT/FLUSH
            // still happens once memory is ready. EX re-presents its
            // redirect/stall then, so they are ignored here.
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
            memw_cnt_d    = sat_inc(memw_cnt_q);
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_redirect) begin
                        // A same-cycle stall belongs to a squashed instruction.
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        state_d     = ST_FLUSH;
                        flush_cnt_d = sat_inc(flush_cnt_q);
                    end else if (stall) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_cnt_d = sat_inc(stall_cnt_q);
                    end
                end
                ST_FLUSH: begin
                    // The IMEM word arriving now is from the wrong path.
                    if_id_flush = 1'b1;
                    if (ex_redirect) begin
                        id_ex_flush = 1'b1;
                        flush_cnt_d = sat_inc(flush_cnt_q);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    // BOOT and the unused encoding: first fetch has no valid
                    // predecessor, so flush both front stages.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = ST_RUN;
                end
            endcase
        end

        if (perf_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
            memw_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            memw_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            memw_cnt_q  <= memw_cnt_d;
        end
    end

    assign fsm_state      = state_q;
    assign stall_count    = stall_cnt_q;
    assign flush_count    = flush_cnt_q;
    assign mem_wait_count = memw_cnt_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
module tb_pipeline_control_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n, stall, ex_redirect, mem_busy, perf_clr;
    logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic             ex_mem_en, mem_wb_bubble;
    logic [1:0]       fsm_state;
    logic [CNT_W-1:0] stall_count, flush_count, mem_wait_count;

    int vecs = 0;
    int errs = 0;

    pipeline_control_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .ex_redirect(ex_redirect),
        .mem_busy(mem_busy), .perf_clr(perf_clr),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_bubble(mem_wb_bubble), .fsm_state(fsm_state),
        .stall_count(stall_count), .flush_count(flush_count),
        .mem_wait_count(mem_wait_count)
    );

    always #5 clk = ~clk;

    // control outputs packed {pc, if_id, id_ex, ex_mem, if_id_flush, id_ex_flush, bubble}
    wire [6:0] ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble};

    task automatic drive(input logic r, input logic s, input logic x, input logic b, input logic c);
        rst_n = r; stall = s; ex_redirect = x; mem_busy = b; perf_clr = c;
    endtask

    // sample point: falling edge, well clear of the active edge
    task automatic settle();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        drive(0, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            settle();
            vecs++;
            if (ctl !== 7'b0000_111) begin
                errs++; $display("FAIL reset_ctl cyc%0d got %b want %b", i, ctl, 7'b0000_111);
            end
            tick();
        end
        vecs++;
        if (fsm_state !== 2'd0 || stall_count !== 0 || flush_count !== 0 || mem_wait_count !== 0) begin
            errs++; $display("FAIL reset_state got st=%0d s=%0d f=%0d m=%0d want 0 0 0 0",
                             fsm_state, stall_count, flush_count, mem_wait_count);
        end
        drive(1, 0, 0, 0, 0);
        settle();
        vecs++;
        if (ctl !== 7'b1111_110 || fsm_state !== 2'd0) begin
            errs++; $display("FAIL boot_cycle got ctl=%b st=%0d want 1111110 st=0", ctl, fsm_state);
        end
        tick();
        vecs++;
        if (fsm_state !== 2'd1) begin
            errs++; $display("FAIL boot_to_run got %0d want 1", fsm_state);
        end
    endtask

    task automatic test_load_use();
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            settle();
            vecs++;
            if (ctl !== 7'b0011_010) begin
                errs++; $display("FAIL load_use_ctl cyc%0d got %b want %b", i, ctl, 7'b0011_010);
            end
            tick();
        end
        drive(1, 0, 0, 0, 0);
        settle();
        vecs++;
        if (stall_count !== 4'd2 || fsm_state !== 2'd1 || ctl !== 7'b1111_000) begin
            errs++; $display("FAIL load_use_count got cnt=%0d st=%0d ctl=%b want 2 1 1111000",
                             stall_count, fsm_state, ctl);
        end
        tick();
    endtask

    task automatic test_redirect_stall();
        drive(1, 0, 0, 0, 1);
        tick();
        drive(1, 1, 1, 0, 0);
        settle();
        vecs++;
        if (ctl !== 7'b1111_110) begin
            errs++; $display("FAIL redir_ctl got %b want %b", ctl, 7'b1111_110);
        end
        tick();
        drive(1, 0, 0, 0, 0);
        settle();
        vecs++;
        if (fsm_state !== 2'd2 || ctl !== 7'b1111_100) begin
            errs++; $display("FAIL redir_flush got st=%0d ctl=%b want 2 1111100", fsm_state, ctl);
        end
        vecs++;
        if (flush_count !== 4'd1 || stall_count !== 4'd0) begin
            errs++; $display("FAIL redir_counts got f=%0d s=%0d want 1 0", flush_count, stall_count);
        end
        tick();
        vecs++;
        if (fsm_state !== 2'd1) begin
            errs++; $display("FAIL redir_back_run got %0d want 1", fsm_state);
        end
    endtask

    task automatic test_freeze_flush();
        drive(1, 0, 0, 0, 1);
        tick();
        drive(1, 0, 1, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 1, 0);
            settle();
            vecs++;
            if (ctl !== 7'b0000_001 || fsm_state !== 2'd2) begin
                errs++; $display("FAIL freeze_ctl cyc%0d got ctl=%b st=%0d want 0000001 2", i, ctl, fsm_state);
            end
            tick();
        end
        drive(1, 0, 0, 0, 0);
        settle();
        vecs++;
        if (fsm_state !== 2'd2 || ctl !== 7'b1111_100) begin
            errs++; $display("FAIL freeze_resume got st=%0d ctl=%b want 2 1111100", fsm_state, ctl);
        end
        vecs++;
        if (mem_wait_count !== 4'd3 || flush_count !== 4'd1 || stall_count !== 4'd0) begin
            errs++; $display("FAIL freeze_counts got m=%0d f=%0d s=%0d want 3 1 0",
                             mem_wait_count, flush_count, stall_count);
        end
        tick();
        vecs++;
        if (fsm_state !== 2'd1) begin
            errs++; $display("FAIL freeze_back_run got %0d want 1", fsm_state);
        end
    endtask

    task automatic test_saturation_clear();
        drive(1, 1, 0, 0, 1);
        tick();
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        settle();
        vecs++;
        if (stall_count !== 4'd15) begin
            errs++; $display("FAIL sat_stall got %0d want 15", stall_count);
        end
        drive(1, 1, 0, 0, 1);
        tick();
        drive(1, 0, 0, 0, 0);
        settle();
        vecs++;
        if (stall_count !== 4'd0 || fsm_state !== 2'd1) begin
            errs++; $display("FAIL clr_beats_inc got cnt=%0d st=%0d want 0 1", stall_count, fsm_state);
        end
        tick();
    endtask

    // Reference model: state 0 BOOT / 1 RUN / 2 FLUSH, counters as plain ints
    task automatic test_random();
        int  st = 0, sc = 0, fc = 0, mc = 0;
        int  maxc = (1 << CNT_W) - 1;
        logic r, s, x, b, c;
        logic [6:0] exp;
        drive(0, 0, 0, 0, 0);
        tick();
        for (int n = 0; n < 600; n++) begin
            r = ($urandom_range(15) != 0);
            b = ($urandom_range(3) == 0);
            x = ($urandom_range(3) == 0);
            s = ($urandom_range(2) == 0);
            c = ($urandom_range(15) == 0);
            drive(r, s, x, b, c);
            if (!r)                          exp = 7'b0000_111;
            else if (b)                      exp = 7'b0000_001;
            else if (st == 0)                exp = 7'b1111_110;
            else if (x)                      exp = 7'b1111_110;
            else if (st == 2)                exp = 7'b1111_100;
            else if (s)                      exp = 7'b0011_010;
            else                             exp = 7'b1111_000;
            settle();
            vecs++;
            if (ctl !== exp || fsm_state !== 2'(st)) begin
                errs++; $display("FAIL rand_ctl n=%0d in=%b%b%b%b got ctl=%b st=%0d want %b %0d",
                                 n, r, b, x, s, ctl, fsm_state, exp, st);
            end
            vecs++;
            if (stall_count !== CNT_W'(sc) || flush_count !== CNT_W'(fc) || mem_wait_count !== CNT_W'(mc)) begin
                errs++; $display("FAIL rand_cnt n=%0d got s=%0d f=%0d m=%0d want %0d %0d %0d",
                                 n, stall_count, flush_count, mem_wait_count, sc, fc, mc);
            end
            if (!r) begin
                st = 0; sc = 0; fc = 0; mc = 0;
            end else begin
                if (b)                     mc = (mc < maxc) ? mc + 1 : mc;
                else if (st != 0 && x)     fc = (fc < maxc) ? fc + 1 : fc;
                else if (st == 1 && s)     sc = (sc < maxc) ? sc + 1 : sc;
                if (c) begin sc = 0; fc = 0; mc = 0; end
                if (!b) begin
                    if (st == 0)      st = 1;
                    else if (x)       st = 2;
                    else              st = 1;
                end
            end
            tick();
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_redirect_stall();
        test_freeze_flush();
        test_saturation_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/pipeline_control_unit.md
# pipeline_control_unit

Central pipeline-register sequencer for the OTTER 5-stage core. It consumes the `stall` request from the hazard detection unit, the EX-stage redirect (taken branch/JAL/JALR) and the data-memory busy flag. From these it drives PC/IF-ID/ID-EX/EX-MEM enables, flushes and bubbles. It owns a small FSM that squashes wrong-path fetches from the synchronous instruction memory, plus saturating performance counters for stall, flush and memory-wait cycles.

## Interface
- `CNT_W`, default 32, width of each performance counter.

- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous active-low reset, sampled on rising edge of `clk`.
- `stall`  in  1  load-use / branch RAW stall request from hazard detection unit.
- `ex_redirect`  in  1  EX-stage control transfer taken this cycle; the PC mux selects the target.
- `mem_busy`  in  1  data memory cannot complete the MEM-stage access this cycle.
- `perf_clr`  in  1  synchronous clear of all counters.
- `pc_en`  out  1  PC register load enable.
- `if_id_en`  out  1  IF/ID load enable.
- `if_id_flush`  out  1  IF/ID loads NOP (overrides data; asserted together with `if_id_en`=1).
- `id_ex_en`  out  1  ID/EX load enable.
- `id_ex_flush`  out  1  ID/EX loads bubble (all control bits 0).
- `ex_mem_en`  out  1  EX/MEM load enable.
- `mem_wb_bubble`  out  1  MEM/WB loads bubble (regWrite=0) instead of MEM result.
- `fsm_state`  out  2  current state: 0 BOOT, 1 RUN, 2 FLUSH.
- `stall_count`  out  CNT_W  hazard-stall cycles.
- `flush_count`  out  CNT_W  accepted redirects.
- `mem_wait_count`  out  CNT_W  cycles with `mem_busy`=1.

## Operation
- Input priority: `rst_n`=0 > `mem_busy` > `ex_redirect` > `stall` > normal.
- Reset (`rst_n`=0 at edge): state ← BOOT, counters ← 0. While `rst_n` is low, outputs are forced: all `*_en`=0, `if_id_flush`=`id_ex_flush`=`mem_wb_bubble`=1.
- Freeze (`mem_busy`=1, any state):
  - `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` = 0; both flushes 0; `mem_wb_bubble`=1.
  - State register holds, so pending BOOT/FLUSH obligations survive.
  - `ex_redirect` and `stall` are ignored; EX is frozen and re-presents them.
  - `mem_wait_count`++.
- BOOT: `pc_en`=1, all other enables 1, `if_id_flush`=`id_ex_flush`=1. Next: RUN.
- RUN:
  - Normal: all enables 1, no flush, `mem_wb_bubble`=0.
  - `ex_redirect`=1 → `pc_en`=1, `if_id_flush`=`id_ex_flush`=1, `ex_mem_en`=1. Next: FLUSH. `flush_count`++. Any simultaneous `stall` is ignored because the stalled instruction is squashed; `stall_count` is unchanged.
  - `stall`=1 (no redirect) → `pc_en`=`if_id_en`=0, `id_ex_flush`=1, `ex_mem_en`=1. Stay in RUN. `stall_count`++.
- FLUSH: squashes the wrong-path word returned by sync IMEM.
  - Outputs: `if_id_flush`=1, all enables 1, `id_ex_flush`=0.
  - `stall` is masked.
  - `ex_redirect`=1 repeats the RUN redirect response, stays in FLUSH and increments `flush_count`.
  - Otherwise next: RUN.
- Counters saturate at all-ones and never wrap.
- `perf_clr` zeroes all counters at the edge and beats any same-cycle increment. State is unaffected.
- Unused state encoding 3 behaves as BOOT and next is RUN.

## Timing
- Control outputs are combinational from the registered state and current inputs. The path is input → output within the same cycle, with no added latency.
- The state register and counters update on the rising edge only. Counter values are visible the cycle after the qualifying event.
- Redirect penalty is 2 cycles: the redirect cycle plus the FLUSH cycle.
- A hazard stall costs 1 bubble per asserted cycle.
- Reset asserted mid-FLUSH or mid-freeze aborts the operation immediately. After reset releases, the first cycle is BOOT.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with all inputs 1 → enables 0, flushes 1, `fsm_state`=0, counters 0. Release: one BOOT cycle with `pc_en`=1 and `if_id_flush`=1, then `fsm_state`=1.
- Load-use: in RUN, `stall`=1 for 2 cycles → `pc_en`=`if_id_en`=0 and `id_ex_flush`=1 both cycles; `stall_count`=2.
- Redirect with stall: `ex_redirect`=1 and `stall`=1 in the same cycle → `pc_en`=1 and both flushes. Next cycle is FLUSH with `if_id_flush`=1 only, then RUN. `flush_count`=1, `stall_count` unchanged.
- Freeze during FLUSH: enter FLUSH, then `mem_busy`=1 for 3 cycles → all enables 0, `mem_wb_bubble`=1, `fsm_state`=2 held. After `mem_busy` drops: one FLUSH cycle, then RUN. `mem_wait_count`=3.
- Saturation/clear: with `CNT_W`=4, assert `stall` for 20 cycles → `stall_count`=15. Then `perf_clr`=1 with `stall`=1 → `stall_count`=0 next cycle.
